// File: rtl/raster_cmd_scheduler.sv
// raster_cmd_scheduler: command FIFO and in-order issue front-end for the
// rasterizer top. DRAWs stream straight through. Clears and fences first wait
// for the downstream pipeline to go quiet, so they never overtake fragments
// that are still in flight.

package raster_pkg;
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } vertex_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        OP_DRAW        = 2'd0,
        OP_CLEAR_FB    = 2'd1,
        OP_CLEAR_DEPTH = 2'd2,
        OP_FENCE       = 2'd3
    } cmd_op_t;
endpackage

// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | wait for a command at the FIFO head; pop it and decode
// S_TRI       | tri_valid high, vertices held until tri_ready
// S_DRAIN     | count consecutive quiet cycles until the pipeline is empty
// S_CLR_ISSUE | one-cycle fb_clear / depth_clear pulse is on the outputs
// S_CLR_WAIT  | skip one cycle, then wait for the selected clearing to fall
module raster_cmd_scheduler
    import raster_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int DRAIN_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  cmd_op,
    input  vertex_t     cmd_v0,
    input  vertex_t     cmd_v1,
    input  vertex_t     cmd_v2,
    input  rgb565_t     cmd_clear_color,
    input  logic [15:0] cmd_clear_depth,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output vertex_t     v0,
    output vertex_t     v1,
    output vertex_t     v2,
    output logic        tri_valid,
    input  logic        tri_ready,
    input  logic        rast_busy,
    input  logic        frag_active,
    output logic        fb_clear,
    output rgb565_t     fb_clear_color,
    input  logic        fb_clearing,
    output logic        depth_clear,
    output logic [15:0] depth_clear_value,
    input  logic        depth_clearing,
    output logic        fence_done,
    output logic [15:0] tris_issued,
    output logic        idle
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int QCNT_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [CNT_W-1:0]  FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [QCNT_W-1:0] QUIET_LAST    = QCNT_W'(DRAIN_CYCLES - 1);

    typedef struct packed {
        logic [1:0]  op;
        vertex_t     v0;
        vertex_t     v1;
        vertex_t     v2;
        rgb565_t     color;
        logic [15:0] depth;
    } cmd_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRI,
        S_DRAIN,
        S_CLR_ISSUE,
        S_CLR_WAIT
    } state_t;

    cmd_entry_t         fifo_mem [FIFO_DEPTH];
    cmd_entry_t         wr_entry;
    cmd_entry_t         head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    state_t             state;
    cmd_op_t            op_q;
    rgb565_t            clr_color_q;
    logic [15:0]        clr_depth_q;
    logic [QCNT_W-1:0]  quiet_cnt;
    logic               wait_first;
    logic [15:0]        tri_cnt_q;
    logic               quiet;
    logic               clearing_sel;

    assign wr_entry.op    = cmd_op;
    assign wr_entry.v0    = cmd_v0;
    assign wr_entry.v1    = cmd_v1;
    assign wr_entry.v2    = cmd_v2;
    assign wr_entry.color = cmd_clear_color;
    assign wr_entry.depth = cmd_clear_depth;

    assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
    assign fifo_empty = (fifo_cnt == '0);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    // The head leaves the FIFO only when IDLE takes it into the working regs.
    assign pop        = (state == S_IDLE) && !fifo_empty;
    assign head       = fifo_mem[rd_ptr];

    assign quiet        = !(rast_busy || frag_active);
    assign clearing_sel = (op_q == OP_CLEAR_FB) ? fb_clearing : depth_clearing;

    assign idle        = (state == S_IDLE) && fifo_empty;
    assign tris_issued = tri_cnt_q;

    // Command storage; data only, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= wr_entry;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Issue sequencer with registered outputs; pulse outputs default low every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            op_q              <= OP_DRAW;
            clr_color_q       <= '0;
            clr_depth_q       <= '0;
            quiet_cnt         <= '0;
            wait_first        <= 1'b0;
            v0                <= '0;
            v1                <= '0;
            v2                <= '0;
            tri_valid         <= 1'b0;
            fb_clear          <= 1'b0;
            fb_clear_color    <= '0;
            depth_clear       <= 1'b0;
            depth_clear_value <= '0;
            fence_done        <= 1'b0;
            tri_cnt_q         <= '0;
        end else begin
            fb_clear    <= 1'b0;
            depth_clear <= 1'b0;
            fence_done  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        op_q        <= cmd_op_t'(head.op);
                        clr_color_q <= head.color;
                        clr_depth_q <= head.depth;
                        if (head.op == OP_DRAW) begin
                            v0        <= head.v0;
                            v1        <= head.v1;
                            v2        <= head.v2;
                            tri_valid <= 1'b1;
                            state     <= S_TRI;
                        end else begin
                            quiet_cnt <= '0;
                            state     <= S_DRAIN;
                        end
                    end
                end

                S_TRI: begin
                    if (tri_ready) begin
                        tri_valid <= 1'b0;
                        tri_cnt_q <= tri_cnt_q + 16'd1;
                        state     <= S_IDLE;
                    end
                end

                S_DRAIN: begin
                    if (!quiet) begin
                        quiet_cnt <= '0;
                    end else if (quiet_cnt == QUIET_LAST) begin
                        // The pulse is raised here so it is visible during CLR_ISSUE.
                        case (op_q)
                            OP_CLEAR_FB: begin
                                fb_clear       <= 1'b1;
                                fb_clear_color <= clr_color_q;
                                state          <= S_CLR_ISSUE;
                            end
                            OP_CLEAR_DEPTH: begin
                                depth_clear       <= 1'b1;
                                depth_clear_value <= clr_depth_q;
                                state             <= S_CLR_ISSUE;
                            end
                            default: begin
                                fence_done <= (op_q == OP_FENCE);
                                state      <= S_IDLE;
                            end
                        endcase
                    end else begin
                        quiet_cnt <= quiet_cnt + QCNT_W'(1);
                    end
                end

                S_CLR_ISSUE: begin
                    wait_first <= 1'b1;
                    state      <= S_CLR_WAIT;
                end

                S_CLR_WAIT: begin
                    // clearing only rises one cycle after the pulse, so the
                    // first cycle here cannot be trusted.
                    if (wait_first) begin
                        wait_first <= 1'b0;
                    end else if (!clearing_sel) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_raster_cmd_scheduler.sv
// Directed bench for raster_cmd_scheduler: reset, back-to-back draws,
// drain-before-clear timing, depth clear + fence, FIFO full, counter wrap.
module tb_raster_cmd_scheduler;
    import raster_pkg::*;

    localparam int DC = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cmd_op;
    vertex_t     cmd_v0, cmd_v1, cmd_v2;
    rgb565_t     cmd_clear_color;
    logic [15:0] cmd_clear_depth;
    logic        cmd_valid;
    logic        cmd_ready;
    vertex_t     v0, v1, v2;
    logic        tri_valid;
    logic        tri_ready;
    logic        rast_busy;
    logic        frag_active;
    logic        fb_clear;
    rgb565_t     fb_clear_color;
    logic        fb_clearing;
    logic        depth_clear;
    logic [15:0] depth_clear_value;
    logic        depth_clearing;
    logic        fence_done;
    logic [15:0] tris_issued;
    logic        idle;

    raster_cmd_scheduler #(.FIFO_DEPTH(4), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .cmd_op(cmd_op), .cmd_v0(cmd_v0), .cmd_v1(cmd_v1),
        .cmd_v2(cmd_v2), .cmd_clear_color(cmd_clear_color), .cmd_clear_depth(cmd_clear_depth),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .v0(v0), .v1(v1), .v2(v2),
        .tri_valid(tri_valid), .tri_ready(tri_ready), .rast_busy(rast_busy),
        .frag_active(frag_active), .fb_clear(fb_clear), .fb_clear_color(fb_clear_color),
        .fb_clearing(fb_clearing), .depth_clear(depth_clear),
        .depth_clear_value(depth_clear_value), .depth_clearing(depth_clearing),
        .fence_done(fence_done), .tris_issued(tris_issued), .idle(idle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_fb = 0, n_dc = 0, n_fe = 0, n_both = 0;
    vertex_t acc_q[$];
    int      acc_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters and triangle-accept log, sampled mid-cycle.
    always @(negedge clk) begin
        if (fb_clear) n_fb++;
        if (depth_clear) n_dc++;
        if (fence_done) n_fe++;
        if (fb_clear && depth_clear) n_both++;
        if (tri_valid && tri_ready) begin
            acc_q.push_back(v0);
            acc_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vertex_t mkv(input int n);
        vertex_t v;
        v.x = 16'(n);
        v.y = 16'(n + 1000);
        v.z = 16'(n + 2000);
        return v;
    endfunction

    task automatic push(input logic [1:0] op, input vertex_t a, input vertex_t b, input vertex_t c,
                        input rgb565_t col, input logic [15:0] dep);
        int n;
        cmd_op = op; cmd_v0 = a; cmd_v1 = b; cmd_v2 = c;
        cmd_clear_color = col; cmd_clear_depth = dep; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin step(); n++; end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL push_ready_timeout got %0b exp 1", cmd_ready); end
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 0; cmd_op = 0; cmd_v0 = '0; cmd_v1 = '0; cmd_v2 = '0;
        cmd_clear_color = '0; cmd_clear_depth = '0; tri_ready = 0; rast_busy = 0;
        frag_active = 0; fb_clearing = 0; depth_clearing = 0;
        repeat (3) step();
        checks++; if (tri_valid !== 1'b0) begin errors++; $display("FAIL reset_tri_valid got %0b exp 0", tri_valid); end
        checks++; if (fb_clear !== 1'b0) begin errors++; $display("FAIL reset_fb_clear got %0b exp 0", fb_clear); end
        checks++; if (depth_clear !== 1'b0) begin errors++; $display("FAIL reset_depth_clear got %0b exp 0", depth_clear); end
        checks++; if (fence_done !== 1'b0) begin errors++; $display("FAIL reset_fence_done got %0b exp 0", fence_done); end
        checks++; if ({v0, v1, v2} !== '0) begin errors++; $display("FAIL reset_vertices got %h exp 0", {v0, v1, v2}); end
        checks++; if (fb_clear_color !== 16'h0000) begin errors++; $display("FAIL reset_fb_color got %h exp 0", fb_clear_color); end
        checks++; if (depth_clear_value !== 16'h0000) begin errors++; $display("FAIL reset_depth_value got %h exp 0", depth_clear_value); end
        checks++; if (tris_issued !== 16'h0000) begin errors++; $display("FAIL reset_tris_issued got %0d exp 0", tris_issued); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0b exp 1", cmd_ready); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %0b exp 1", idle); end
        rst = 1'b0;
        repeat (3) step();
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL post_reset_idle got %0b exp 1", idle); end
        checks++; if (n_fb + n_dc + n_fe !== 0) begin errors++; $display("FAIL post_reset_pulses got %0d exp 0", n_fb + n_dc + n_fe); end
    endtask

    task automatic test_back_to_back();
        int n;
        vertex_t got;
        logic held_ok;
        tri_ready = 1'b0;
        acc_q.delete(); acc_cyc.delete();
        push(OP_DRAW, mkv(1), mkv(2), mkv(3), '0, '0);
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL b2b_idle_after_push got %0b exp 0", idle); end
        push(OP_DRAW, mkv(4), mkv(5), mkv(6), '0, '0);
        push(OP_DRAW, mkv(7), mkv(8), mkv(9), '0, '0);
        held_ok = 1'b1;
        repeat (5) begin
            if (tri_valid !== 1'b1 || v0 !== mkv(1) || v1 !== mkv(2) || v2 !== mkv(3)) held_ok = 1'b0;
            step();
        end
        checks++; if (held_ok !== 1'b1) begin errors++; $display("FAIL b2b_hold_first got %0b exp 1", held_ok); end
        tri_ready = 1'b1;
        n = 0;
        while (acc_q.size() < 3 && n < 50) begin step(); n++; end
        step();
        checks++; if (acc_q.size() !== 3) begin errors++; $display("FAIL b2b_accept_count got %0d exp 3", acc_q.size()); end
        for (int i = 0; i < 3; i++) begin
            got = (i < acc_q.size()) ? acc_q[i] : '0;
            checks++; if (got !== mkv(1 + 3 * i)) begin errors++; $display("FAIL b2b_order_%0d got %h exp %h", i, got, mkv(1 + 3 * i)); end
        end
        if (acc_cyc.size() == 3) begin
            checks++; if (acc_cyc[1] - acc_cyc[0] !== 2) begin errors++; $display("FAIL b2b_gap0 got %0d exp 2", acc_cyc[1] - acc_cyc[0]); end
            checks++; if (acc_cyc[2] - acc_cyc[1] !== 2) begin errors++; $display("FAIL b2b_gap1 got %0d exp 2", acc_cyc[2] - acc_cyc[1]); end
        end
        checks++; if (tris_issued !== 16'd3) begin errors++; $display("FAIL b2b_tris_issued got %0d exp 3", tris_issued); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL b2b_idle got %0b exp 1", idle); end
    endtask

    task automatic test_clear_fb();
        int n, last_act, fb0, c;
        logic [5:0] pat;
        logic bad_tv;
        tri_ready = 1'b1;
        fb0 = n_fb;
        bad_tv = 1'b0;
        push(OP_DRAW, mkv(10), mkv(11), mkv(12), '0, '0);
        push(OP_CLEAR_FB, '0, '0, '0, 16'hF800, '0);
        push(OP_DRAW, mkv(20), mkv(21), mkv(22), '0, '0);
        rast_busy = 1'b1;
        repeat (10) step();
        rast_busy = 1'b0;
        pat = 6'b100101;
        last_act = cyc;
        for (int i = 0; i < 6; i++) begin
            frag_active = pat[i];
            if (pat[i]) last_act = cyc;
            step();
        end
        frag_active = 1'b0;
        n = 0;
        while (!fb_clear && n < 100) begin
            if (tri_valid) bad_tv = 1'b1;
            step(); n++;
        end
        checks++; if (fb_clear !== 1'b1) begin errors++; $display("FAIL fb_pulse_timeout got %0b exp 1", fb_clear); end
        checks++; if (cyc !== last_act + DC + 1) begin errors++; $display("FAIL fb_pulse_cycle got %0d exp %0d", cyc, last_act + DC + 1); end
        checks++; if (fb_clear_color !== 16'hF800) begin errors++; $display("FAIL fb_color_at_pulse got %h exp f800", fb_clear_color); end
        checks++; if (depth_clear !== 1'b0) begin errors++; $display("FAIL fb_no_depth_pulse got %0b exp 0", depth_clear); end
        step();
        checks++; if (fb_clear !== 1'b0) begin errors++; $display("FAIL fb_pulse_width got %0b exp 0", fb_clear); end
        fb_clearing = 1'b1;
        repeat (6) begin
            step();
            if (tri_valid) bad_tv = 1'b1;
        end
        fb_clearing = 1'b0;
        c = cyc;
        step();
        checks++; if (tri_valid !== 1'b0) begin errors++; $display("FAIL fb_draw_early at cyc %0d got %0b exp 0", c + 1, tri_valid); end
        step();
        checks++; if (tri_valid !== 1'b1) begin errors++; $display("FAIL fb_draw_issue got %0b exp 1", tri_valid); end
        checks++; if (v0 !== mkv(20)) begin errors++; $display("FAIL fb_draw_vertex got %h exp %h", v0, mkv(20)); end
        checks++; if (bad_tv !== 1'b0) begin errors++; $display("FAIL fb_draw_overtook got %0b exp 0", bad_tv); end
        step();
        checks++; if (tris_issued !== 16'd5) begin errors++; $display("FAIL fb_tris_issued got %0d exp 5", tris_issued); end
        checks++; if (n_fb - fb0 !== 1) begin errors++; $display("FAIL fb_pulse_count got %0d exp 1", n_fb - fb0); end
        checks++; if (fb_clear_color !== 16'hF800) begin errors++; $display("FAIL fb_color_held got %h exp f800", fb_clear_color); end
    endtask

    task automatic test_clear_depth_fence();
        int n, dc0, fe0, c;
        dc0 = n_dc; fe0 = n_fe;
        push(OP_CLEAR_DEPTH, '0, '0, '0, '0, 16'hFFFF);
        push(OP_FENCE, '0, '0, '0, '0, '0);
        n = 0;
        while (!depth_clear && n < 100) begin step(); n++; end
        checks++; if (depth_clear !== 1'b1) begin errors++; $display("FAIL dc_pulse_timeout got %0b exp 1", depth_clear); end
        checks++; if (depth_clear_value !== 16'hFFFF) begin errors++; $display("FAIL dc_value got %h exp ffff", depth_clear_value); end
        checks++; if (fb_clear !== 1'b0) begin errors++; $display("FAIL dc_no_fb_pulse got %0b exp 0", fb_clear); end
        step();
        checks++; if (depth_clear !== 1'b0) begin errors++; $display("FAIL dc_pulse_width got %0b exp 0", depth_clear); end
        depth_clearing = 1'b1;
        repeat (8) begin
            step();
            if (fence_done) n_fe = n_fe + 100;
        end
        depth_clearing = 1'b0;
        c = cyc;
        n = 0;
        while (!fence_done && n < 100) begin step(); n++; end
        checks++; if (fence_done !== 1'b1) begin errors++; $display("FAIL fence_timeout got %0b exp 1", fence_done); end
        checks++; if (cyc !== c + DC + 2) begin errors++; $display("FAIL fence_cycle got %0d exp %0d", cyc, c + DC + 2); end
        step();
        checks++; if (fence_done !== 1'b0) begin errors++; $display("FAIL fence_width got %0b exp 0", fence_done); end
        checks++; if (n_fe - fe0 !== 1) begin errors++; $display("FAIL fence_count got %0d exp 1", n_fe - fe0); end
        checks++; if (n_dc - dc0 !== 1) begin errors++; $display("FAIL dc_count got %0d exp 1", n_dc - dc0); end
        checks++; if (depth_clear_value !== 16'hFFFF) begin errors++; $display("FAIL dc_value_held got %h exp ffff", depth_clear_value); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL fence_idle got %0b exp 1", idle); end
    endtask

    task automatic test_fifo_full();
        int n;
        logic ok;
        vertex_t got;
        tri_ready = 1'b0;
        acc_q.delete(); acc_cyc.delete();
        ok = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cmd_op = OP_DRAW; cmd_v0 = mkv(i * 10); cmd_v1 = mkv(i * 10 + 1); cmd_v2 = mkv(i * 10 + 2);
            cmd_valid = 1'b1;
            if (cmd_ready !== 1'b1) ok = 1'b0;
            step();
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_ready_before_fill got %0b exp 1", ok); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready_at_4 got %0b exp 0", cmd_ready); end
        cmd_v0 = mkv(60); cmd_v1 = mkv(61); cmd_v2 = mkv(62);
        ok = 1'b1;
        repeat (3) begin
            step();
            if (cmd_ready !== 1'b0 || tri_valid !== 1'b1 || v0 !== mkv(10)) ok = 1'b0;
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_stall_hold got %0b exp 1", ok); end
        tri_ready = 1'b1;
        step();
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready_before_pop got %0b exp 0", cmd_ready); end
        step();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %0b exp 1", cmd_ready); end
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (acc_q.size() < 6 && n < 60) begin step(); n++; end
        step();
        checks++; if (acc_q.size() !== 6) begin errors++; $display("FAIL full_accept_count got %0d exp 6", acc_q.size()); end
        for (int i = 0; i < 6; i++) begin
            got = (i < acc_q.size()) ? acc_q[i] : '0;
            checks++; if (got !== mkv((i + 1) * 10)) begin errors++; $display("FAIL full_order_%0d got %h exp %h", i, got, mkv((i + 1) * 10)); end
        end
        checks++; if (tris_issued !== 16'd11) begin errors++; $display("FAIL full_tris_issued got %0d exp 11", tris_issued); end
    endtask

    task automatic test_wrap();
        force dut.tri_cnt_q = 16'hFFFF;
        step();
        release dut.tri_cnt_q;
        step();
        checks++; if (tris_issued !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset got %h exp ffff", tris_issued); end
        tri_ready = 1'b1;
        push(OP_DRAW, mkv(77), mkv(78), mkv(79), '0, '0);
        repeat (4) step();
        checks++; if (tris_issued !== 16'h0000) begin errors++; $display("FAIL wrap_tris_issued got %h exp 0", tris_issued); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL wrap_idle got %0b exp 1", idle); end
    endtask

    task automatic test_reset_mid_drain();
        int pulses0;
        tri_ready = 1'b0;
        rast_busy = 1'b1;
        push(OP_CLEAR_FB, '0, '0, '0, 16'h07E0, '0);
        push(OP_CLEAR_DEPTH, '0, '0, '0, '0, 16'h1234);
        push(OP_FENCE, '0, '0, '0, '0, '0);
        push(OP_DRAW, mkv(90), mkv(91), mkv(92), '0, '0);
        step();
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL mid_idle_before got %0b exp 0", idle); end
        rst = 1'b1;
        #1;
        checks++; if (tri_valid !== 1'b0) begin errors++; $display("FAIL mid_tri_valid got %0b exp 0", tri_valid); end
        checks++; if ({v0, v1, v2} !== '0) begin errors++; $display("FAIL mid_vertices got %h exp 0", {v0, v1, v2}); end
        checks++; if (fb_clear_color !== 16'h0000) begin errors++; $display("FAIL mid_fb_color got %h exp 0", fb_clear_color); end
        checks++; if (depth_clear_value !== 16'h0000) begin errors++; $display("FAIL mid_depth_value got %h exp 0", depth_clear_value); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_cmd_ready got %0b exp 1", cmd_ready); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle got %0b exp 1", idle); end
        pulses0 = n_fb + n_dc + n_fe;
        step();
        step();
        rst = 1'b0;
        rast_busy = 1'b0;
        repeat (50) step();
        checks++; if (n_fb + n_dc + n_fe !== pulses0) begin errors++; $display("FAIL mid_pulses_after_release got %0d exp %0d", n_fb + n_dc + n_fe, pulses0); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle_after got %0b exp 1", idle); end
        checks++; if (tri_valid !== 1'b0) begin errors++; $display("FAIL mid_tri_valid_after got %0b exp 0", tri_valid); end
        checks++; if (n_both !== 0) begin errors++; $display("FAIL both_clears_same_cycle got %0d exp 0", n_both); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_clear_fb();
        test_clear_depth_fence();
        test_fifo_full();
        test_wrap();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
